// File: rtl/muxn1_valid_rr.sv
// N:1 valid/ready multiplexer with a registered, back-pressurable output stage.
// Define MUXN1_RR_EN to compile in round-robin arbitration (mode=1); otherwise manual select only.
module muxn1_valid_rr #(
  parameter int WIDTH    = 2,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          select,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam logic [SEL_W:0] CH_CNT = (SEL_W+1)'(CHANNELS);

  logic             can_load;
  logic             man_ok;
  logic             has_cand;
  logic             transfer;
  logic [SEL_W-1:0] cand;
  logic [WIDTH-1:0] data_sel;
  logic [WIDTH-1:0] chan_data [CHANNELS];

  assign can_load = !out_valid || out_ready;
  assign man_ok   = {1'b0, select} < CH_CNT;

`ifdef MUXN1_RR_EN
  logic [SEL_W-1:0]      ptr_reg;
  logic                  rr_found;
  logic [SEL_W-1:0]      rr_idx;
  logic [SEL_W:0]        scan;
  logic [2**SEL_W-1:0]   valid_pad;

  assign valid_pad = (2**SEL_W)'(in_valid);

  // Cyclic scan starting just after the last round-robin winner.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    scan     = '0;
    for (int k = 1; k <= CHANNELS; k++) begin
      scan = {1'b0, ptr_reg} + (SEL_W+1)'(k);
      if (scan >= CH_CNT) scan = scan - CH_CNT;
      if (!rr_found && valid_pad[scan[SEL_W-1:0]]) begin
        rr_found = 1'b1;
        rr_idx   = scan[SEL_W-1:0];
      end
    end
  end

  assign has_cand = mode ? rr_found : man_ok;
  assign cand     = mode ? rr_idx   : select;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_reg <= SEL_W'(CHANNELS-1);
    end else if (transfer && mode) begin
      ptr_reg <= cand;
    end
  end
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign has_cand    = man_ok;
  assign cand        = select;
`endif

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      assign chan_data[gi] = in_data[gi*WIDTH +: WIDTH];
      assign in_ready[gi]  = reset && can_load && has_cand &&
                             (cand == SEL_W'(gi)) && in_valid[gi];
    end
  endgenerate

  assign transfer = |in_ready;

  // in_ready is one-hot, so an OR of the gated channels is the data mux.
  always_comb begin
    data_sel = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (in_ready[i]) data_sel = data_sel | chan_data[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_data  <= '0;
      out_chan  <= '0;
      out_valid <= 1'b0;
    end else if (can_load) begin
      out_valid <= transfer;
      if (transfer) begin
        out_data <= data_sel;
        out_chan <= cand;
      end
    end
  end

endmodule

// File: tb/tb_muxn1_valid_rr.sv
// Directed bench for muxn1_valid_rr (CHANNELS=4, WIDTH=2, SEL_W=3) with an output scoreboard.
// Round-robin steps are compiled only when MUXN1_RR_EN is defined.
module tb_muxn1_valid_rr;

  logic       clk;
  logic       reset;
  logic       mode;
  logic [2:0] select;
  logic [7:0] in_data;
  logic [3:0] in_valid;
  logic [3:0] in_ready;
  logic [1:0] out_data;
  logic [2:0] out_chan;
  logic       out_valid;
  logic       out_ready;

  int tests = 0;
  int fails = 0;
  logic [4:0] exp_q [$];
  logic [1:0] last_data;
  logic [2:0] last_chan;

  muxn1_valid_rr #(.WIDTH(2), .CHANNELS(4), .SEL_W(3)) dut (
    .clk(clk), .reset(reset), .mode(mode), .select(select),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called just after a negedge with inputs set; ends at the next negedge.
  task automatic step(input string tag, input logic [3:0] exp_rdy, input logic exp_v);
    logic [4:0] w;
    int c;
    #1;
    check({tag, " in_ready"}, {28'd0, in_ready}, {28'd0, exp_rdy});
    if (exp_rdy != 4'd0) begin
      c = 0;
      for (int i = 0; i < 4; i++) if (exp_rdy[i]) c = i;
      exp_q.push_back({3'(c), in_data[c*2 +: 2]});
    end
    @(posedge clk);
    #1;
    check({tag, " out_valid"}, {31'd0, out_valid}, {31'd0, exp_v});
    if (exp_rdy != 4'd0) begin
      w = exp_q.pop_front();
      last_data = w[1:0];
      last_chan = w[4:2];
    end
    check({tag, " out_data"}, {30'd0, out_data}, {30'd0, last_data});
    check({tag, " out_chan"}, {29'd0, out_chan}, {29'd0, last_chan});
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    exp_q.delete();
    last_data = 2'd0;
    last_chan = 3'd0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; mode = 1'b0; select = 3'd0; in_data = 8'd0;
    in_valid = 4'b1111; out_ready = 1'b1;
    last_data = 2'd0; last_chan = 3'd0;
    @(negedge clk);
    check("rst in_ready", {28'd0, in_ready}, 32'd0);
    check("rst out_valid", {31'd0, out_valid}, 32'd0);
    check("rst out_data", {30'd0, out_data}, 32'd0);
    check("rst out_chan", {29'd0, out_chan}, 32'd0);
    reset = 1'b1;
    in_valid = 4'b0000;

    // Manual select of channel 2, then an out-of-range select.
    select = 3'd2; in_data = 8'b0011_0000; in_valid = 4'b0100;
    step("man sel2", 4'b0100, 1'b1);
    select = 3'd5;
    step("man sel5", 4'b0000, 1'b0);

    // Back-to-back manual transfers across every channel.
    in_valid = 4'b1111;
    for (int s = 0; s < 4; s++) begin
      select = 3'(s);
      in_data = 8'($urandom);
      step("man stream", 4'(1 << s), 1'b1);
    end
    select = 3'd1; in_valid = 4'b0100;
    step("man notvalid", 4'b0000, 1'b0);

    // Backpressure: 3 stalled cycles, then release with a new word waiting.
    select = 3'd3; in_valid = 4'b1000; in_data = 8'b1000_0000;
    step("bp load", 4'b1000, 1'b1);
    out_ready = 1'b0; select = 3'd0; in_valid = 4'b0001; in_data = 8'b0000_0001;
    for (int s = 0; s < 3; s++) step("bp stall", 4'b0000, 1'b1);
    out_ready = 1'b1;
    step("bp release", 4'b0001, 1'b1);
    in_valid = 4'b0000;
    step("bp drain", 4'b0000, 1'b0);

    // Asynchronous reset while stalled: clears outputs with no clock edge.
    select = 3'd2; in_valid = 4'b0100; in_data = 8'b0010_0000;
    step("ar load", 4'b0100, 1'b1);
    out_ready = 1'b0; in_valid = 4'b0000;
    #2 reset = 1'b0;
    #1;
    check("ar out_valid", {31'd0, out_valid}, 32'd0);
    check("ar out_data", {30'd0, out_data}, 32'd0);
    check("ar out_chan", {29'd0, out_chan}, 32'd0);
    out_ready = 1'b1;
    do_reset();

`ifdef MUXN1_RR_EN
    // Fairness with all channels valid.
    mode = 1'b1; in_valid = 4'b1111;
    for (int s = 0; s < 8; s++) begin
      in_data = 8'($urandom);
      step("rr fair", 4'(1 << (s % 4)), 1'b1);
    end
    // Sparse pattern from reset, then channel 0 joins after ptr reaches 3.
    do_reset();
    in_valid = 4'b1010;
    for (int s = 0; s < 4; s++) begin
      in_data = 8'($urandom);
      step("rr sparse", (s % 2 == 0) ? 4'b0010 : 4'b1000, 1'b1);
    end
    in_valid = 4'b1011;
    step("rr wrap", 4'b0001, 1'b1);
    in_valid = 4'b0000;
    step("rr idle", 4'b0000, 1'b0);
`else
    // Manual-only build ignores mode.
    mode = 1'b1; select = 3'd1; in_valid = 4'b1111;
    for (int s = 0; s < 4; s++) begin
      in_data = 8'($urandom);
      step("norr mode", 4'b0010, 1'b1);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/muxn1_valid_rr.md
# muxn1_valid_rr

Parametrised N:1 multiplexer with per-channel valid/ready handshakes and a registered, back-pressurable output stage. It generalises the 2:1 2-bit valid multiplexer to any data width and channel count. It adds a round-robin arbitration mode alongside manual select. It sits between several producer channels and a single consumer in the datapath.

## Interface
Parameters:
- WIDTH, 2, data bits per channel
- CHANNELS, 4, number of input channels (≥2)
- SEL_W, 2, select/channel-index width; must satisfy 2^SEL_W ≥ CHANNELS

Ports:
- clk  input  1  single clock; all state on rising edge
- reset  input  1  asynchronous, active-low reset
- mode  input  1  0 = manual (use select), 1 = round-robin
- select  input  SEL_W  manual channel index
- in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  CHANNELS  per-channel data valid
- in_ready  output  CHANNELS  one-hot grant; channel i transfers when in_valid[i] & in_ready[i]
- out_data  output  WIDTH  registered selected data
- out_chan  output  SEL_W  index of channel that supplied out_data
- out_valid  output  1  out_data holds an unconsumed word
- out_ready  input  1  consumer accepts out_data when out_valid & out_ready

## Operation
- Output register "can load" = !out_valid | out_ready.
- Candidate channel:
  - Manual: candidate = select. If select ≥ CHANNELS, there is no candidate.
  - Round-robin: scan cyclically from ptr+1 and take the first i with in_valid[i]=1. If no in_valid bit is set, there is no candidate.
- in_ready[candidate] = can_load & in_valid[candidate]. All other in_ready bits are 0, and in_ready is all 0 when there is no candidate.
- The in_ready path is combinational from in_valid, mode, select, out_valid and out_ready. There is no combinational path from in_data to any output.
- On a transfer from channel c: out_data ← in_data[c], out_chan ← c, out_valid ← 1. In round-robin mode only, ptr ← c.
- When can_load is true and no transfer occurs: out_valid ← 0, and out_data/out_chan hold their previous values.
- When can_load is false (stall: out_valid=1, out_ready=0): out_data, out_chan and out_valid hold, and in_ready is all 0.
- ptr is updated only by round-robin transfers. Manual transfers leave ptr unchanged, and switching mode does not clear it.
- Changes to mode or select take effect on the current cycle's combinational grant.
- Ordering within a channel is preserved. Across channels, order follows the grant sequence.

## Timing
- Reset (reset=0, asynchronous, immediate):
  - out_data=0, out_chan=0, out_valid=0, ptr=CHANNELS-1, so channel 0 has first priority.
  - in_ready=0 while reset is asserted.
  - A word held in the output register is discarded.
- Latency: a word accepted at edge k appears on out_data with out_valid=1 after edge k, i.e. 1 cycle.
- Throughput: 1 word/cycle while out_ready=1. A simultaneous consume and load at the same edge produces no bubble.
- Round-robin wrap: with ptr=CHANNELS-1, the scan order is 0,1,…,CHANNELS-1.
- Round-robin fairness: with all channels continuously valid and out_ready=1, each channel is granted exactly once in any CHANNELS consecutive transfers.
- Boundary cases:
  - select out of range: no transfer, out_valid drains normally.
  - All in_valid=0: no transfer.
  - Stall: inputs are not accepted.

## Configuration
- MUXN1_RR_EN defined: round-robin logic and ptr are compiled in, and mode behaves as specified above.
- MUXN1_RR_EN undefined: the block is manual-select only. mode is ignored, and ptr and the scan logic are absent. All other behaviour and all ports are unchanged.

## Test plan
- Reset mid-stall: set out_valid=1, out_ready=0, then pulse reset low. Expect out_valid=0, out_data=0, out_chan=0 immediately, with no clock edge required.
- Manual select: CHANNELS=4, WIDTH=2, mode=0, select=2, in_data ch2=2'b11, in_valid=4'b0100, out_ready=1. Expect in_ready=4'b0100, then out_data=2'b11, out_chan=2, out_valid=1 after one edge. Then set select=5 (SEL_W=3 build). Expect in_ready=0 and out_valid=0 on the next edge.
- Round-robin fairness: mode=1, in_valid=4'b1111, out_ready=1 for 8 cycles. Expect out_chan sequence 0,1,2,3,0,1,2,3.
- Round-robin sparse: mode=1, in_valid=4'b1010 starting from reset. Expect grants 1,3,1,3. After ptr=3, raise in_valid[0]. Expect the next grant to be 0.
- Backpressure: hold out_ready=0 for 3 cycles with out_valid=1. Expect out_data and out_chan stable, in_ready=0. Then set out_ready=1 with the next word valid. Expect the new word on the following edge with out_valid staying 1.
- Build with MUXN1_RR_EN undefined: mode=1, select=1, in_valid=4'b1111. Expect grants always to channel 1.
